// File: rtl/fetch_unit_pkg.sv
// Shared CPU defines for the fetch stage: bubble word, reset PC, FSM encoding.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 16;

    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 16'h0800;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_e;

    // Instruction word paired with its return address (fetched address + 1).
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    // PC increment; wraps 16'hFFFF -> 16'h0000 by width truncation.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return XLEN'(pc + XLEN'(1));
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, same-cycle ack/data back.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem reads, buffers a word across stalls,
// and discards in-flight reads made stale by a branch redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    fetch_unit_if.master        imem,
    output logic [XLEN-1:0]     pc_out,
    output logic [XLEN-1:0]     instr_out,
    output logic                instr_valid,
    output logic [XLEN-1:0]     fetch_cnt
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] kill_addr, kill_addr_nxt;
    fetch_word_t     buf_word, buf_word_nxt;
    fetch_word_t     out_nxt;
    logic            valid_nxt;
    logic            upd;
    logic            req_q, req_nxt;
    logic [XLEN-1:0] addr_q, addr_nxt;

    assign imem.req  = req_q;
    assign imem.addr = addr_q;

    // Redirect overrides stall; outputs only move on an update cycle.
    assign upd = !stall || redirect;

    // State register, PC, holding buffer and registered imem request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            kill_addr <= '0;
            buf_word  <= '{instr: NOP_INSTR, pc: '0};
            req_q     <= 1'b1;
            addr_q    <= RESET_PC;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            kill_addr <= kill_addr_nxt;
            buf_word  <= buf_word_nxt;
            req_q     <= req_nxt;
            addr_q    <= addr_nxt;
        end
    end

    // Output register toward IF/ID plus delivered-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_out   <= NOP_INSTR;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            fetch_cnt   <= '0;
        end else if (upd) begin
            instr_out   <= out_nxt.instr;
            pc_out      <= out_nxt.pc;
            instr_valid <= valid_nxt;
            if (valid_nxt) begin
                fetch_cnt <= XLEN'(fetch_cnt + XLEN'(1));
            end
        end
    end

    // Next-state, PC and output selection; default output is a bubble.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        kill_addr_nxt = kill_addr;
        buf_word_nxt  = buf_word;
        out_nxt       = '{instr: NOP_INSTR, pc: '0};
        valid_nxt     = 1'b0;

        unique case (state)
            ST_FETCH: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                    if (!imem.ack) begin
                        kill_addr_nxt = pc;
                        state_nxt     = ST_KILL;
                    end
                end else if (imem.ack) begin
                    pc_nxt = pc_inc(pc);
                    if (stall) begin
                        buf_word_nxt = '{instr: imem.rdata, pc: pc_inc(pc)};
                        state_nxt    = ST_HOLD;
                    end else begin
                        out_nxt   = '{instr: imem.rdata, pc: pc_inc(pc)};
                        valid_nxt = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_nxt       = redirect_pc;
                    buf_word_nxt = '{instr: NOP_INSTR, pc: '0};
                    state_nxt    = ST_FETCH;
                end else if (!stall) begin
                    out_nxt   = buf_word;
                    valid_nxt = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_KILL: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
                if (imem.ack) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase

        // Address held stable until ack; KILL keeps presenting the stale address.
        req_nxt  = (state_nxt != ST_HOLD);
        addr_nxt = (state_nxt == ST_KILL) ? kill_addr_nxt : pc_nxt;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected deliveries.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc_out;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [15:0] fetch_cnt;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .fetch_cnt   (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    fetch_word_t sb[$];
    logic [15:0] exp_cnt;
    logic [15:0] last_instr;
    logic [15:0] last_pc;
    logic        last_valid;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Expected output kind for one edge: delivery, bubble, or hold.
    typedef enum {K_DELIV, K_BUBBLE, K_HOLD} kind_e;

    // Drive inputs, clock once, then check outputs and the next imem request.
    task automatic step(input string tag, input logic ack, input logic [15:0] rdata,
                        input logic stl, input logic rdr, input logic [15:0] rpc,
                        input kind_e kind, input logic exp_req, input logic [15:0] exp_addr);
        fetch_word_t w;
        imem.ack    = ack;
        imem.rdata  = rdata;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
        case (kind)
            K_DELIV: begin
                if (sb.size() == 0) begin
                    n_total++;
                    $error("FAIL %s scoreboard empty observed_valid=%b expected=delivery", tag, instr_valid);
                end else begin
                    w = sb.pop_front();
                    exp_cnt = 16'(exp_cnt + 16'd1);
                    last_instr = w.instr; last_pc = w.pc; last_valid = 1'b1;
                end
            end
            K_BUBBLE: begin
                last_instr = NOP; last_pc = 16'h0000; last_valid = 1'b0;
            end
            default: ;
        endcase
        chk({tag, ".valid"}, 16'(instr_valid), 16'(last_valid));
        chk({tag, ".instr"}, instr_out, last_instr);
        chk({tag, ".pc_out"}, pc_out, last_pc);
        chk({tag, ".cnt"}, fetch_cnt, exp_cnt);
        chk({tag, ".req"}, 16'(imem.req), 16'(exp_req));
        if (exp_req) chk({tag, ".addr"}, imem.addr, exp_addr);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 16'(instr_valid), 16'h0000);
        chk({tag, ".instr"}, instr_out, NOP);
        chk({tag, ".pc_out"}, pc_out, 16'h0000);
        chk({tag, ".cnt"}, fetch_cnt, 16'h0000);
        chk({tag, ".req"}, 16'(imem.req), 16'h0001);
        chk({tag, ".addr"}, imem.addr, 16'h0000);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem.ack = 1'b0; imem.rdata = 16'h0000;
        exp_cnt = 16'h0000; last_instr = NOP; last_pc = 16'h0000; last_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        // Late ack: three bubbles with the address held at the reset PC.
        step("wait0", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, K_BUBBLE, 1'b1, 16'h0000);
        step("wait1", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, K_BUBBLE, 1'b1, 16'h0000);
        step("wait2", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, K_BUBBLE, 1'b1, 16'h0000);
        sb.push_back('{instr: 16'h6801, pc: 16'h0001});
        step("ack0", 1'b1, 16'h6801, 1'b0, 1'b0, 16'h0, K_DELIV, 1'b1, 16'h0001);

        // Back-to-back acks, one delivery per cycle.
        for (int i = 1; i <= 3; i++) begin
            sb.push_back('{instr: 16'h6801, pc: 16'(i + 1)});
            step($sformatf("stream%0d", i), 1'b1, 16'h6801, 1'b0, 1'b0, 16'h0,
                 K_DELIV, 1'b1, 16'(i + 1));
        end

        // Stall during an ack: word buffered, request dropped, delivered after stall.
        sb.push_back('{instr: 16'h4F02, pc: 16'h0005});
        step("stall_ack", 1'b1, 16'h4F02, 1'b1, 1'b0, 16'h0, K_HOLD, 1'b0, 16'h0000);
        step("stall_hold", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, K_HOLD, 1'b0, 16'h0000);
        step("stall_rel", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, K_DELIV, 1'b1, 16'h0005);

        // Redirect while 0x0005 is pending: stale ack discarded, then fetch 0x0040.
        step("pend", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, K_BUBBLE, 1'b1, 16'h0005);
        step("redir_kill", 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, K_BUBBLE, 1'b1, 16'h0005);
        step("kill_wait", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, K_BUBBLE, 1'b1, 16'h0005);
        step("kill_ack", 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0, K_BUBBLE, 1'b1, 16'h0040);
        sb.push_back('{instr: 16'h1234, pc: 16'h0041});
        step("tgt_ack", 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, K_DELIV, 1'b1, 16'h0041);

        // Redirect and stall together, from FETCH with ack and from HOLD.
        step("rs_fetch", 1'b1, 16'hBEEF, 1'b1, 1'b1, 16'h0100, K_BUBBLE, 1'b1, 16'h0100);
        step("to_hold", 1'b1, 16'h5555, 1'b1, 1'b0, 16'h0, K_HOLD, 1'b0, 16'h0000);
        step("rs_hold", 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, K_BUBBLE, 1'b1, 16'h0200);

        // Redirect inside KILL retargets the PC; stale address still presented.
        step("to_kill", 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0300, K_BUBBLE, 1'b1, 16'h0200);
        step("redir_in_kill", 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, K_BUBBLE, 1'b1, 16'h0200);
        step("kill_done", 1'b1, 16'h9999, 1'b0, 1'b0, 16'h0, K_BUBBLE, 1'b1, 16'hFFFF);

        // PC wrap at the top of the address space.
        sb.push_back('{instr: 16'h7777, pc: 16'h0000});
        step("wrap", 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0, K_DELIV, 1'b1, 16'h0000);

        // Async reset asserted while clk is high, no edge in between.
        imem.ack = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("async_rst");
        exp_cnt = 16'h0000; last_instr = NOP; last_pc = 16'h0000; last_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb.push_back('{instr: 16'h2222, pc: 16'h0001});
        step("post_rst", 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0, K_DELIV, 1'b1, 16'h0001);

        chk("sb_empty", 16'(sb.size()), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0800, SHALL be the bubble instruction word.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 stall  in  1  SHALL be the hazard hold; the same signal drives ifkeep of the IF/ID register.
REQ-006 redirect  in  1  SHALL be the branch/jump taken indication from ID.
REQ-007 redirect_pc  in  16  SHALL be the branch/jump target address.
REQ-008 imem_req  out  1  SHALL be the instruction-memory read request.
REQ-009 imem_addr  out  16  SHALL be the instruction-memory word address.
REQ-010 imem_ack  in  1  SHALL be the read-complete strobe; data is valid in the same cycle.
REQ-011 imem_rdata  in  16  SHALL be the instruction word read.
REQ-012 pc_out  out  16  SHALL be the fetched address + 1, toward IF/ID pc_in.
REQ-013 instr_out  out  16  SHALL be the fetched instruction, toward IF/ID instr_in.
REQ-014 instr_valid  out  1  SHALL be high when instr_out is a real instruction; IF/ID ifClear = !instr_valid.
REQ-015 fetch_cnt  out  16  SHALL be the count of delivered instructions, for LED debug.

Function
REQ-016 FSM states SHALL be FETCH (request outstanding), HOLD (buffered word, downstream stalled), and KILL (discard outstanding request).
REQ-017 FETCH: imem_req=1, imem_addr=pc.
REQ-018 KILL: imem_req=1, imem_addr=kill_addr.
REQ-019 HOLD: imem_req=0.
REQ-020 imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-021 Outputs pc_out, instr_out, instr_valid SHALL be registered and SHALL update only when stall=0 or redirect=1; otherwise they hold.
REQ-022 FETCH, ack=1, redirect=0, stall=0: instr_out<=imem_rdata, pc_out<=pc+1, instr_valid<=1, pc<=pc+1, stay FETCH; latency is ack cycle to output in 1 clock.
REQ-023 FETCH, ack=1, redirect=0, stall=1: buf<=imem_rdata, buf_pc<=pc+1, pc<=pc+1, go to HOLD; outputs hold.
REQ-024 FETCH, ack=0, redirect=0, stall=0: bubble (instr_out<=NOP_INSTR, pc_out<=0, instr_valid<=0).
REQ-025 HOLD, stall=0, redirect=0: outputs <= buf/buf_pc, instr_valid<=1, go to FETCH.
REQ-026 redirect SHALL take priority over stall in every state; it loads pc<=redirect_pc and bubbles the outputs.
REQ-027 Redirect in FETCH with ack=1 SHALL discard the data and stay in FETCH.
REQ-028 Redirect in FETCH with ack=0 SHALL set kill_addr<=pc and go to KILL.
REQ-029 Redirect in HOLD SHALL drop buf and go to FETCH.
REQ-030 Redirect in KILL SHALL update pc and stay in KILL.
REQ-031 KILL, ack=1: the data SHALL be discarded and the FSM SHALL go to FETCH; outputs bubble if stall=0.
REQ-032 pc+1 SHALL wrap 16'hFFFF -> 16'h0000; pc_out for address 16'hFFFF is 16'h0000.
REQ-033 fetch_cnt SHALL increment (modulo 2^16) on each cycle instr_valid is loaded with 1.

Reset
REQ-034 rst=0 SHALL immediately force: state=FETCH, pc=RESET_PC, instr_out=NOP_INSTR, pc_out=0, instr_valid=0, fetch_cnt=0, buf=NOP_INSTR, kill_addr=0.
REQ-035 Reset mid-request SHALL abandon the outstanding access; the first request after reset release is to RESET_PC.

Structure
REQ-036 NOP_INSTR, RESET_PC and FSM state encodings SHALL live in the shared CPU defines header.
REQ-037 Single module; no sub-module.

Verification
REQ-038 Reset, ack every cycle with rdata=16'h6801, stall=0 -> instr_valid=1 from the 2nd edge, pc_out 1,2,3..., fetch_cnt increments per cycle.
REQ-039 ack delayed 3 cycles -> 3 bubbles (instr_out=16'h0800, instr_valid=0), imem_addr held at 0.
REQ-040 stall=1 for 2 cycles during ack of 16'h4F02 -> outputs hold, HOLD entered, imem_req=0; word delivered on the cycle after stall falls.
REQ-041 Redirect to 16'h0040 while a request to 16'h0005 is pending -> KILL, late ack discarded, next imem_addr=16'h0040, no 16'h0005 data appears.
REQ-042 redirect and stall both high -> pc=redirect_pc, outputs bubble.
REQ-043 pc=16'hFFFF fetch -> pc_out=16'h0000, next imem_addr=16'h0000; async rst asserted mid-cycle -> outputs reset without a clock edge.
